uart_to_ram: RTL and testbench
==============================

// Module: uart_to_ram
// PURPOSE
//  UART receiver that deserialises bytes from the host and writes them into packet-buffer BRAM over the write port.
//  Writes fill an address window [write_start, write_end); write_end is exclusive.
//  Receive-side counterpart of the RAM-to-UART dump path; used to preload frames for Ethernet TX and encryption tests.
// PARAMETERS
//  CLKS_PER_BIT   434  clk cycles per UART bit (50 MHz / 115200 baud); minimum 4
//  RAM_SIZE_LOG2  11   BRAM address width
//  BYTE_LEN       8    data bits per UART frame
// PORTS
//  clk              in   1              system clock (50 MHz)
//  reset_n          in   1              asynchronous, active-low reset
//  start            in   1              arm a capture session (1-cycle pulse)
//  write_start      in   RAM_SIZE_LOG2  first address of window, sampled on accepted start
//  write_end        in   RAM_SIZE_LOG2  one past last address, sampled on accepted start
//  uart_rxd         in   1              asynchronous serial input, idle high
//  ram_write_enable out  1              1-cycle write strobe
//  ram_write_addr   out  RAM_SIZE_LOG2  write address
//  ram_write_val    out  BYTE_LEN       write data
//  busy             out  1              session armed
//  done             out  1              1-cycle pulse when window is full
//  err_count        out  8              saturating count of rejected frames
// BEHAVIOUR
//  Reset: async assert clears all state; all outputs 0; rx synchroniser flops preset to 1.
//  Synchronise uart_rxd with 2 flops; all FSM logic uses the synchronised bit.
//  RX FSM (always runs, armed or not, so it stays in frame sync with the host):
//   IDLE: on rxd low, load bit counter with CLKS_PER_BIT/2 and go to START.
//   START: when counter expires, sample rxd. If low, go to DATA. If high (glitch), go back to IDLE.
//   DATA: sample at mid-bit every CLKS_PER_BIT cycles; LSB first; BYTE_LEN samples, then go to STOP.
//   STOP: sample at mid-bit. If 1, byte is valid; go to IDLE.
//         If 0, framing error: err_count++ (saturates at 255), discard byte, go to BREAK.
//   BREAK: wait for rxd high, then go to IDLE.
//  Session:
//   start while !busy: latch curr_addr=write_start and end_addr=write_end; busy<=1.
//   start while busy: ignored.
//   Valid byte while busy: on the cycle after the stop-bit sample, ram_write_enable=1 for exactly 1 cycle,
//   with ram_write_addr=curr_addr and ram_write_val=byte; curr_addr<=curr_addr+1 (mod 2^RAM_SIZE_LOG2).
//   If curr_addr+1 == end_addr: done=1 in that same cycle and busy<=0.
//   Valid byte while !busy: dropped; no write.
//   write_start == write_end: window is all 2^RAM_SIZE_LOG2 bytes (wraps once).
//   Windows wrap through address 0 when write_end < write_start.
//  ram_write_addr/val hold their last values when not strobing.
//  Worst-case byte throughput is 1 per (BYTE_LEN+2)*CLKS_PER_BIT cycles; no back-pressure, BRAM always accepts.
//  A start arriving mid-frame arms the session; that in-flight byte is written if it completes validly.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: RX FSM adds a PARITY state after DATA that samples one even-parity bit.
//   Parity mismatch: err_count++, byte discarded, continue to STOP normally (no BREAK unless stop bit is bad).
//  Undefined: 8N1 framing; no parity state; the bit after the data bits is the stop bit.
// TESTING
//  Use CLKS_PER_BIT=8.
//  1 reset_n low, then high: all outputs 0, busy=0. Send 0xA5 while idle -> no write strobe; err_count=0.
//  2 start with window [0x010,0x013); send 0x11,0x22,0x33 -> writes (0x010,0x11),(0x011,0x22),(0x012,0x33);
//    done with third strobe; busy=0 after.
//  3 window [0x7FE,0x001); send 3 bytes -> addresses 0x7FE, 0x7FF, 0x000; done on third.
//  4 Send 0x55 with stop bit forced 0, hold line low 3 bit times, then send 0x66 -> err_count=1; only 0x66 written.
//  5 Apply a 2-cycle low glitch on idle rxd -> no frame received, no error. Pulse start twice while busy -> window unchanged.
//  6 Drop reset_n mid-DATA -> outputs 0 immediately. Resume and send 0x77 after start -> written at new write_start.
//    With UART_RX_PARITY_EN: a bad parity bit increments err_count and produces no write.

Source files
------------

// File: rtl/uart_to_ram.sv
// uart_to_ram: UART receiver that writes received bytes into a BRAM address window.
//   A capture session is armed by a start pulse, which latches [write_start, write_end).
//   Every valid byte received while armed is written to consecutive addresses, wrapping
//   modulo 2^RAM_SIZE_LOG2. The session ends with a done pulse when the window is full.
//   The RX framer runs whether or not a session is armed, so it stays in frame sync.
// Optional feature macro: UART_RX_PARITY_EN (adds one even-parity bit after the data bits).
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start                arm a capture session (ignored while busy)
//   write_start/_end     window bounds, sampled on an accepted start (end exclusive)
//   uart_rxd             asynchronous serial input, idle high
//   ram_write_enable     1-cycle write strobe; ram_write_addr/ram_write_val hold otherwise
//   busy                 session armed
//   done                 1-cycle pulse with the strobe that fills the window
//   err_count            saturating count of rejected frames
module uart_to_ram #(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned RAM_SIZE_LOG2 = 11,
    parameter int unsigned BYTE_LEN      = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [RAM_SIZE_LOG2-1:0] write_start,
    input  logic [RAM_SIZE_LOG2-1:0] write_end,
    input  logic                     uart_rxd,
    output logic                     ram_write_enable,
    output logic [RAM_SIZE_LOG2-1:0] ram_write_addr,
    output logic [BYTE_LEN-1:0]      ram_write_val,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               err_count
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(BYTE_LEN + 1);

    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(BYTE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } rx_state_t;

    rx_state_t                state;
    logic                     rxd_meta;
    logic                     rxd_sync;
    logic [CNT_W-1:0]         cnt;
    logic [IDX_W-1:0]         bit_idx;
    logic [BYTE_LEN-1:0]      shreg;
    logic                     par_err;
    logic [RAM_SIZE_LOG2-1:0] curr_addr;
    logic [RAM_SIZE_LOG2-1:0] end_addr;
    logic [RAM_SIZE_LOG2-1:0] next_addr;
    logic [7:0]               err_inc;

    assign next_addr = curr_addr + 1'b1;
    assign err_inc   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

    // Synchroniser, RX framer and session control share one register process.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta         <= 1'b1;
            rxd_sync         <= 1'b1;
            state            <= S_IDLE;
            cnt              <= '0;
            bit_idx          <= '0;
            shreg            <= '0;
            par_err          <= 1'b0;
            curr_addr        <= '0;
            end_addr         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            ram_write_enable <= 1'b0;
            ram_write_addr   <= '0;
            ram_write_val    <= '0;
            err_count        <= '0;
        end else begin
            rxd_meta         <= uart_rxd;
            rxd_sync         <= rxd_meta;
            ram_write_enable <= 1'b0;
            done             <= 1'b0;

            // Arm a session; a start while armed leaves the window untouched.
            if (start && !busy) begin
                curr_addr <= write_start;
                end_addr  <= write_end;
                busy      <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (!rxd_sync) begin
                        cnt   <= HALF_RELOAD;
                        state <= S_START;
                    end
                end

                // Re-check the start bit at its middle to reject short glitches.
                S_START: begin
                    if (cnt == '0) begin
                        if (!rxd_sync) begin
                            cnt     <= BIT_RELOAD;
                            bit_idx <= '0;
                            par_err <= 1'b0;
                            state   <= S_DATA;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // LSB first: shift in from the top.
                S_DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rxd_sync, shreg[BYTE_LEN-1:1]};
                        cnt   <= BIT_RELOAD;
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                // Even parity: data bits plus parity bit must XOR to zero.
                S_PARITY: begin
                    if (cnt == '0) begin
                        if (rxd_sync != ^shreg) begin
                            par_err   <= 1'b1;
                            err_count <= err_inc;
                        end
                        cnt   <= BIT_RELOAD;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (cnt == '0) begin
                        if (rxd_sync) begin
                            state <= S_IDLE;
                            if (busy && !par_err) begin
                                ram_write_enable <= 1'b1;
                                ram_write_addr   <= curr_addr;
                                ram_write_val    <= shreg;
                                curr_addr        <= next_addr;
                                if (next_addr == end_addr) begin
                                    done <= 1'b1;
                                    busy <= 1'b0;
                                end
                            end
                        end else begin
                            err_count <= err_inc;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // Framing error: wait out a held-low line before hunting for a start bit.
                S_BREAK: begin
                    if (rxd_sync) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_to_ram.sv
// tb_uart_to_ram: drives serial frames into uart_to_ram and checks writes, done,
// busy and err_count against a queue-based model of the capture session.
module tb_uart_to_ram;

    localparam int unsigned CPB = 8;
    localparam int unsigned AW  = 11;
    localparam int unsigned BL  = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] write_start;
    logic [AW-1:0] write_end;
    logic          uart_rxd;
    logic          ram_write_enable;
    logic [AW-1:0] ram_write_addr;
    logic [BL-1:0] ram_write_val;
    logic          busy;
    logic          done;
    logic [7:0]    err_count;

    always #5 clk = ~clk;

    uart_to_ram #(
        .CLKS_PER_BIT (CPB),
        .RAM_SIZE_LOG2(AW),
        .BYTE_LEN     (BL)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .write_start     (write_start),
        .write_end       (write_end),
        .uart_rxd        (uart_rxd),
        .ram_write_enable(ram_write_enable),
        .ram_write_addr  (ram_write_addr),
        .ram_write_val   (ram_write_val),
        .busy            (busy),
        .done            (done),
        .err_count       (err_count)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    val;
        logic          fin;
    } wr_t;

    int            n_checks = 0;
    int            n_errs   = 0;
    wr_t           exp_q[$];
    bit            m_busy = 1'b0;
    logic [AW-1:0] m_curr = '0;
    logic [AW-1:0] m_end  = '0;
    int            m_err  = 0;
    logic [AW-1:0] last_addr = '0;
    logic [7:0]    last_val  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every strobe must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (ram_write_enable) begin
                last_addr = ram_write_addr;
                last_val  = ram_write_val;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL unexpected_write: addr %0h val %0h, expected no write at %0t",
                             ram_write_addr, ram_write_val, $time);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(ram_write_addr), 32'(e.addr));
                    check("wr_val",  32'(ram_write_val),  32'(e.val));
                    check("wr_done", 32'(done),           32'(e.fin));
                end
            end else if (done) begin
                check("done_without_write", 32'(done), 32'd0);
            end
        end
    end

    // Session model: what a valid byte must produce.
    task automatic model_byte(input logic [7:0] b);
        wr_t e;
        if (m_busy) begin
            e.addr = m_curr;
            e.val  = b;
            e.fin  = (AW'(m_curr + 1'b1) == m_end);
            exp_q.push_back(e);
            m_curr = AW'(m_curr + 1'b1);
            if (e.fin) m_busy = 1'b0;
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] ws, input logic [AW-1:0] we);
        write_start = ws;
        write_end   = we;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (!m_busy) begin
            m_busy = 1'b1;
            m_curr = ws;
            m_end  = we;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic hold_line(input logic v, input int cycles);
        uart_rxd = v;
        repeat (cycles) @(negedge clk);
    endtask

    // Drives one frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par);
        hold_line(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        hold_line((^b) ^ bad_par, CPB);
`else
        if (bad_par) hold_line(1'b1, 0);
`endif
        hold_line(stop_bit, CPB);
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b1, 1'b0);
        hold_line(1'b1, CPB);
    endtask

    task automatic settle(input string tag);
        hold_line(1'b1, 2 * CPB);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy"},    32'(busy),         32'(m_busy));
        check({tag, "_err"},     32'(err_count),    32'(m_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},   32'(ram_write_enable), 32'd0);
        check({tag, "_addr"}, 32'(ram_write_addr),   32'd0);
        check({tag, "_val"},  32'(ram_write_val),    32'd0);
        check({tag, "_busy"}, 32'(busy),             32'd0);
        check({tag, "_done"}, 32'(done),             32'd0);
        check({tag, "_err"},  32'(err_count),        32'd0);
    endtask

    initial begin
        logic [AW-1:0] ws;
        int            len;

        reset_n     = 1'b0;
        start       = 1'b0;
        write_start = '0;
        write_end   = '0;
        uart_rxd    = 1'b1;
        @(negedge clk);
        check_all_zero("reset_held");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_released");

        // Byte while idle is dropped.
        send_byte(8'hA5);
        settle("idle_byte");

        // Simple window.
        pulse_start(11'h010, 11'h013);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        settle("window");
        check("window_last_addr", 32'(last_addr), 32'h012);
        check("window_last_val",  32'(last_val),  32'h33);

        // Window wrapping through address 0.
        pulse_start(11'h7FE, 11'h001);
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        settle("wrap");
        check("wrap_last_addr", 32'(last_addr), 32'h000);

        // Framing error with a held-low break, then a good byte.
        pulse_start(11'h050, 11'h051);
        m_err++;
        send_frame(8'h55, 1'b0, 1'b0);
        hold_line(1'b0, 3 * CPB);
        hold_line(1'b1, CPB);
        send_byte(8'h66);
        settle("framing");
        check("framing_err_literal", 32'(err_count), 32'd1);
        check("framing_last_val",    32'(last_val),  32'h66);

        // Short glitch, and starts while busy are ignored.
        hold_line(1'b0, 2);
        settle("glitch");
        pulse_start(11'h100, 11'h104);
        pulse_start(11'h200, 11'h202);
        send_byte(8'h01);
        pulse_start(11'h300, 11'h302);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        settle("restart_ignored");
        check("restart_last_addr", 32'(last_addr), 32'h103);

`ifdef UART_RX_PARITY_EN
        pulse_start(11'h080, 11'h082);
        m_err++;
        send_frame(8'h3C, 1'b1, 1'b1);
        hold_line(1'b1, CPB);
        settle("bad_parity");
        send_byte(8'h3D);
        send_byte(8'h3E);
        settle("parity_recover");
`endif

        // Randomised windows with interleaved glitches and framing errors.
        for (int t = 0; t < 12; t++) begin
            ws  = AW'($urandom_range(0, 2047));
            len = int'($urandom_range(1, 4));
            if ($urandom_range(0, 2) == 0) send_byte(8'($urandom));
            pulse_start(ws, AW'(ws + AW'(len)));
            for (int k = 0; k < len; k++) begin
                case ($urandom_range(0, 5))
                    0: hold_line(1'b0, 2);
                    1: begin
                        m_err++;
                        send_frame(8'($urandom), 1'b0, 1'b0);
                        hold_line(1'b0, CPB);
                        hold_line(1'b1, CPB);
                    end
                    default: ;
                endcase
                send_byte(8'($urandom));
            end
            settle("random");
        end

        // Reset in the middle of the data bits.
        pulse_start(11'h400, 11'h410);
        hold_line(1'b0, CPB);
        hold_line(1'b1, CPB);
        hold_line(1'b0, CPB / 2);
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_data");
        m_busy = 1'b0;
        m_err  = 0;
        exp_q.delete();
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        hold_line(1'b1, 2 * CPB);
        pulse_start(11'h345, 11'h346);
        send_byte(8'h77);
        settle("after_reset");
        check("after_reset_addr", 32'(last_addr), 32'h345);
        check("after_reset_val",  32'(last_val),  32'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
